// File: rtl/sockit_spi_pkg.sv
// Shared SPI stream types: arbitration mode, arbiter FSM states and the
// command flag bit positions used by the arbiter and the serializer.
package sockit_spi_pkg;

  typedef enum logic {ARB_RR = 1'b0, ARB_FIX = 1'b1} arb_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_st_t;

  localparam int SPI_CMD_WRB = 0;
  localparam int SPI_CMD_RDB = 1;
  localparam int SPI_CMD_ENB = 2;

endpackage

// File: rtl/sockit_spi_arb_fifo.sv
// Register FIFO of owner tags; remembers which port must source the next
// write word or sink the next read word.
module sockit_spi_arb_fifo #(
  parameter int TW = 1,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [TW-1:0] din,
  input  logic          pop,
  output logic [TW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(FD);

  logic [TW-1:0] mem [FD];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  // a full FIFO refuses a push even when a pop frees a slot this cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == (AW+1)'(FD));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sockit_spi_arb.sv
// N-port arbiter in front of the serializer stream triple: grants are held
// for a whole SPI transaction, data words are routed via owner-tag FIFOs.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int PN  = 2,
  parameter int CW  = 32,
  parameter int DW  = 32,
  parameter int FD  = 4,
  parameter int ARB = 0,
  parameter int WRB = SPI_CMD_WRB,
  parameter int RDB = SPI_CMD_RDB,
  parameter int ENB = SPI_CMD_ENB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PN-1:0]          en,
  input  logic [PN-1:0]          usc_vld,
  output logic [PN-1:0]          usc_rdy,
  input  logic [PN*CW-1:0]       usc_dat,
  input  logic [PN-1:0]          usw_vld,
  output logic [PN-1:0]          usw_rdy,
  input  logic [PN*DW-1:0]       usw_dat,
  output logic [PN-1:0]          usr_vld,
  input  logic [PN-1:0]          usr_rdy,
  output logic [DW-1:0]          usr_dat,
  output logic                   dsc_vld,
  output logic [CW-1:0]          dsc_dat,
  input  logic                   dsc_rdy,
  output logic                   dsw_vld,
  output logic [DW-1:0]          dsw_dat,
  input  logic                   dsw_rdy,
  input  logic                   dsr_vld,
  input  logic [DW-1:0]          dsr_dat,
  output logic                   dsr_rdy,
  output logic [$clog2(PN)-1:0]  own,
  output logic                   lck
);

  localparam int TW = $clog2(PN);

  arb_st_t       st_q, st_d;
  logic [TW-1:0] own_q, own_d, rr_q, rr_d, pick;
  logic [PN-1:0] req;
  logic [CW-1:0] cmd;
  logic          blk, acc;

  logic          wf_push, wf_pop, wf_full, wf_empty;
  logic          rf_push, rf_pop, rf_full, rf_empty;
  logic [TW-1:0] wf_head, rf_head;

  assign req = en & usc_vld;
  assign cmd = usc_dat[int'(own_q)*CW +: CW];

  // descending scan: the last hit is the first port in search order
  always_comb begin
    pick = '0;
    for (int i = PN; i >= 1; i--) begin
      if (ARB == int'(ARB_FIX)) begin
        if (req[i-1]) pick = TW'(i-1);
      end else if (req[(int'(rr_q) + i) % PN]) begin
        pick = TW'((int'(rr_q) + i) % PN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      own_q <= '0;
      rr_q  <= TW'(PN-1);
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      rr_q  <= rr_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    own_d = own_q;
    rr_d  = rr_q;
    case (st_q)
      ST_IDLE: if (|req) begin
        st_d  = ST_LOCK;
        own_d = pick;
      end
      ST_LOCK: if (acc && cmd[ENB]) begin
        st_d = ST_IDLE;
        rr_d = own_q;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // dsc_vld depends only on the owner's valid and FIFO space, never on dsc_rdy
  always_comb begin
    blk     = (cmd[WRB] & wf_full) | (cmd[RDB] & rf_full);
    dsc_vld = (st_q == ST_LOCK) & usc_vld[own_q] & ~blk;
    dsc_dat = cmd;
    acc     = dsc_vld & dsc_rdy;
  end

  assign lck = (st_q == ST_LOCK);
  assign own = own_q;

  assign wf_push = acc & cmd[WRB];
  assign rf_push = acc & cmd[RDB];

  assign dsw_vld = ~wf_empty & usw_vld[wf_head];
  assign dsw_dat = usw_dat[int'(wf_head)*DW +: DW];
  assign wf_pop  = dsw_vld & dsw_rdy;

  assign dsr_rdy = ~rf_empty & usr_rdy[rf_head];
  assign usr_dat = dsr_dat;
  assign rf_pop  = dsr_vld & dsr_rdy;

  for (genvar p = 0; p < PN; p++) begin : g_port
    assign usc_rdy[p] = acc & (own_q == TW'(p));
    assign usw_rdy[p] = ~wf_empty & dsw_rdy & (wf_head == TW'(p));
    assign usr_vld[p] = ~rf_empty & dsr_vld & (rf_head == TW'(p));
  end

  sockit_spi_arb_fifo #(.TW(TW), .FD(FD)) wf (
    .clk(clk), .rst(rst), .push(wf_push), .din(own_q), .pop(wf_pop),
    .head(wf_head), .full(wf_full), .empty(wf_empty)
  );

  sockit_spi_arb_fifo #(.TW(TW), .FD(FD)) rf (
    .clk(clk), .rst(rst), .push(rf_push), .din(own_q), .pop(rf_pop),
    .head(rf_head), .full(rf_full), .empty(rf_empty)
  );

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Bench for sockit_spi_arb: a round-robin and a fixed-priority instance share
// stimulus; fp selects which instance the handshakes and checks follow.
module tb_sockit_spi_arb;

  localparam int PN = 3;
  localparam int CW = 16;
  localparam int DW = 16;
  localparam int FD = 2;
  localparam int TW = 2;
  localparam logic [2:0] F_WR = 3'b001, F_RD = 3'b010, F_EN = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fp  = 1'b0;
  logic [PN-1:0]    en = '1, usc_vld = '0, usw_vld = '0, usr_rdy = '1;
  logic [PN*CW-1:0] usc_dat = '0;
  logic [PN*DW-1:0] usw_dat = '0;
  logic             dsc_rdy = 1'b1, dsw_rdy = 1'b1, dsr_vld = 1'b0;
  logic [DW-1:0]    dsr_dat = '0;

  logic [PN-1:0] rr_usc_rdy, rr_usw_rdy, rr_usr_vld, fp_usc_rdy, fp_usw_rdy, fp_usr_vld;
  logic [DW-1:0] rr_usr_dat, rr_dsw_dat, fp_usr_dat, fp_dsw_dat;
  logic [CW-1:0] rr_dsc_dat, fp_dsc_dat;
  logic          rr_dsc_vld, rr_dsw_vld, rr_dsr_rdy, rr_lck;
  logic          fp_dsc_vld, fp_dsw_vld, fp_dsr_rdy, fp_lck;
  logic [TW-1:0] rr_own, fp_own;

  logic [PN-1:0] m_usc_rdy, m_usw_rdy, m_usr_vld;
  logic [DW-1:0] m_usr_dat, m_dsw_dat;
  logic [CW-1:0] m_dsc_dat;
  logic          m_dsc_vld, m_dsw_vld, m_dsr_rdy, m_lck;
  logic [TW-1:0] m_own;

  always #5 clk = ~clk;

  sockit_spi_arb #(.PN(PN), .CW(CW), .DW(DW), .FD(FD), .ARB(0)) u_rr (
    .clk(clk), .rst(rst), .en(en),
    .usc_vld(usc_vld), .usc_rdy(rr_usc_rdy), .usc_dat(usc_dat),
    .usw_vld(usw_vld), .usw_rdy(rr_usw_rdy), .usw_dat(usw_dat),
    .usr_vld(rr_usr_vld), .usr_rdy(usr_rdy), .usr_dat(rr_usr_dat),
    .dsc_vld(rr_dsc_vld), .dsc_dat(rr_dsc_dat), .dsc_rdy(dsc_rdy),
    .dsw_vld(rr_dsw_vld), .dsw_dat(rr_dsw_dat), .dsw_rdy(dsw_rdy),
    .dsr_vld(dsr_vld), .dsr_dat(dsr_dat), .dsr_rdy(rr_dsr_rdy),
    .own(rr_own), .lck(rr_lck)
  );

  sockit_spi_arb #(.PN(PN), .CW(CW), .DW(DW), .FD(FD), .ARB(1)) u_fp (
    .clk(clk), .rst(rst), .en(en),
    .usc_vld(usc_vld), .usc_rdy(fp_usc_rdy), .usc_dat(usc_dat),
    .usw_vld(usw_vld), .usw_rdy(fp_usw_rdy), .usw_dat(usw_dat),
    .usr_vld(fp_usr_vld), .usr_rdy(usr_rdy), .usr_dat(fp_usr_dat),
    .dsc_vld(fp_dsc_vld), .dsc_dat(fp_dsc_dat), .dsc_rdy(dsc_rdy),
    .dsw_vld(fp_dsw_vld), .dsw_dat(fp_dsw_dat), .dsw_rdy(dsw_rdy),
    .dsr_vld(dsr_vld), .dsr_dat(dsr_dat), .dsr_rdy(fp_dsr_rdy),
    .own(fp_own), .lck(fp_lck)
  );

  assign m_usc_rdy = fp ? fp_usc_rdy : rr_usc_rdy;
  assign m_usw_rdy = fp ? fp_usw_rdy : rr_usw_rdy;
  assign m_usr_vld = fp ? fp_usr_vld : rr_usr_vld;
  assign m_usr_dat = fp ? fp_usr_dat : rr_usr_dat;
  assign m_dsw_dat = fp ? fp_dsw_dat : rr_dsw_dat;
  assign m_dsc_dat = fp ? fp_dsc_dat : rr_dsc_dat;
  assign m_dsc_vld = fp ? fp_dsc_vld : rr_dsc_vld;
  assign m_dsw_vld = fp ? fp_dsw_vld : rr_dsw_vld;
  assign m_dsr_rdy = fp ? fp_dsr_rdy : rr_dsr_rdy;
  assign m_lck     = fp ? fp_lck : rr_lck;
  assign m_own     = fp ? fp_own : rr_own;

  int checks = 0;
  int errors = 0;

  // per-port source queues and the scoreboard of expected downstream traffic
  logic [CW-1:0] cq [PN][$];
  logic [DW-1:0] wq [PN][$];
  logic [DW-1:0] dq [$];
  logic [CW-1:0] exp_c [$];
  logic [DW-1:0] exp_w [$];
  logic [DW+1:0] exp_r [$];

  // command word: [15:8] sequence, [5:4] issuing port, [2:0] flags
  function automatic logic [CW-1:0] mk(input int port, input int seq, input logic [2:0] fl);
    return {8'(seq), 2'b00, 2'(port), 1'b0, fl};
  endfunction

  task automatic push_cmd(input int port, input int seq, input logic [2:0] fl, input bit expect_it);
    cq[port].push_back(mk(port, seq, fl));
    if (expect_it) exp_c.push_back(mk(port, seq, fl));
  endtask

  task automatic drive();
    for (int p = 0; p < PN; p++) begin
      usc_vld[p] = (cq[p].size() > 0);
      usc_dat[p*CW +: CW] = (cq[p].size() > 0) ? cq[p][0] : '0;
      usw_vld[p] = (wq[p].size() > 0);
      usw_dat[p*DW +: DW] = (wq[p].size() > 0) ? wq[p][0] : '0;
    end
    dsr_vld = (dq.size() > 0);
    dsr_dat = (dq.size() > 0) ? dq[0] : 16'h5A5A;
  endtask

  // one clock: scoreboard compare at negedge, then retire accepted words
  task automatic step();
    logic [PN-1:0] ac, aw;
    logic          ar;
    logic [CW-1:0] ec;
    logic [DW-1:0] ew;
    logic [DW+1:0] er;
    @(negedge clk);
    if (m_dsc_vld && dsc_rdy) begin
      checks++;
      if (exp_c.size() == 0) begin
        errors++;
        $display("FAIL cmd_extra: got %h, none expected", m_dsc_dat);
      end else begin
        ec = exp_c.pop_front();
        if (m_dsc_dat !== ec || m_own !== ec[5:4]) begin
          errors++;
          $display("FAIL cmd_order: got %h own %0d, expected %h own %0d", m_dsc_dat, m_own, ec, ec[5:4]);
        end
      end
    end
    if (m_dsw_vld && dsw_rdy) begin
      checks++;
      if (exp_w.size() == 0) begin
        errors++;
        $display("FAIL wdat_extra: got %h, none expected", m_dsw_dat);
      end else begin
        ew = exp_w.pop_front();
        if (m_dsw_dat !== ew) begin
          errors++;
          $display("FAIL wdat: got %h, expected %h", m_dsw_dat, ew);
        end
      end
    end
    for (int p = 0; p < PN; p++) begin
      if (m_usr_vld[p] && usr_rdy[p]) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL rdat_extra: port %0d got %h, none expected", p, m_usr_dat);
        end else begin
          er = exp_r.pop_front();
          if ({2'(p), m_usr_dat} !== er) begin
            errors++;
            $display("FAIL rdat: port %0d data %h, expected port %0d data %h", p, m_usr_dat, er[DW+1:DW], er[DW-1:0]);
          end
        end
      end
    end
    ac = usc_vld & m_usc_rdy;
    aw = usw_vld & m_usw_rdy;
    ar = dsr_vld & m_dsr_rdy;
    @(posedge clk);
    #1;
    for (int p = 0; p < PN; p++) begin
      if (ac[p]) void'(cq[p].pop_front());
      if (aw[p]) void'(wq[p].pop_front());
    end
    if (ar) void'(dq.pop_front());
    drive();
  endtask

  task automatic run(input int budget, output int n);
    n = 0;
    while ((exp_c.size() > 0 || exp_w.size() > 0 || exp_r.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_c.size() > 0 || exp_w.size() > 0 || exp_r.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d cmd %0d wdat %0d rdat pending after %0d cycles, required 0",
               exp_c.size(), exp_w.size(), exp_r.size(), budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fp = 1'b0; en = '1; dsc_rdy = 1'b1; dsw_rdy = 1'b1; usr_rdy = '1;
    for (int p = 0; p < PN; p++) begin
      cq[p].delete();
      wq[p].delete();
    end
    dq.delete(); exp_c.delete(); exp_w.delete(); exp_r.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    usc_vld = '1; usw_vld = '1; dsr_vld = 1'b1; dsr_dat = 16'h5A5A;
    @(posedge clk);
    #1;
    checks++;
    if (m_lck !== 1'b0 || m_own !== '0) begin
      errors++;
      $display("FAIL reset_state: lck %b own %0d, required 0 0", m_lck, m_own);
    end
    checks++;
    if ({m_dsc_vld, m_usc_rdy, m_dsw_vld, m_usw_rdy, m_usr_vld, m_dsr_rdy} !== '0) begin
      errors++;
      $display("FAIL reset_hs: dsc_vld %b usc_rdy %b dsw_vld %b usw_rdy %b usr_vld %b dsr_rdy %b, required all 0",
               m_dsc_vld, m_usc_rdy, m_dsw_vld, m_usw_rdy, m_usr_vld, m_dsr_rdy);
    end
    checks++;
    if (m_usr_dat !== 16'h5A5A) begin
      errors++;
      $display("FAIL reset_usr_dat: got %h, required 5a5a", m_usr_dat);
    end
    do_reset();
  endtask

  task automatic test_rr_fairness();
    int n;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < PN; p++) begin
        push_cmd(p, 2*k, 3'b000, 1'b1);
        push_cmd(p, 2*k+1, F_EN, 1'b1);
      end
    drive();
    run(60, n);
    // six transactions of arbitrate + 2 accepts each
    checks++;
    if (n !== 18) begin
      errors++;
      $display("FAIL rr_cycles: took %0d cycles, required 18", n);
    end
    do_reset();
  endtask

  task automatic test_fixed_priority();
    int n;
    fp = 1'b1;
    for (int k = 0; k < 3; k++) push_cmd(0, k, F_EN, 1'b1);
    push_cmd(2, 0, F_EN, 1'b1);
    drive();
    run(40, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL fp_cycles: took %0d cycles, required 8", n);
    end
    do_reset();
  endtask

  task automatic test_lock_enable();
    int n;
    push_cmd(1, 0, 3'b000, 1'b1);
    drive();
    step();
    step();
    en = 3'b101;
    push_cmd(1, 1, 3'b000, 1'b1);
    push_cmd(1, 2, F_EN, 1'b1);
    push_cmd(0, 0, F_EN, 1'b1);
    push_cmd(1, 9, F_EN, 1'b0);
    drive();
    #1;
    checks++;
    if (m_lck !== 1'b1 || m_own !== 2'd1) begin
      errors++;
      $display("FAIL lock_hold: lck %b own %0d, required 1 1", m_lck, m_own);
    end
    run(30, n);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      checks++;
      if (m_lck !== 1'b0 || m_dsc_vld !== 1'b0) begin
        errors++;
        $display("FAIL disabled_regrant: lck %b dsc_vld %b, required 0 0", m_lck, m_dsc_vld);
      end
    end
    do_reset();
  endtask

  task automatic test_read_routing();
    int n;
    usr_rdy = 3'b110;
    push_cmd(0, 0, F_RD, 1'b1);
    push_cmd(0, 1, F_RD | F_EN, 1'b1);
    push_cmd(1, 0, F_RD | F_EN, 1'b1);
    dq.push_back(16'h00A0); dq.push_back(16'h00A1); dq.push_back(16'h00B0);
    exp_r.push_back({2'd0, 16'h00A0});
    exp_r.push_back({2'd0, 16'h00A1});
    exp_r.push_back({2'd1, 16'h00B0});
    drive();
    for (int i = 0; i < 20 && exp_c.size() > 0; i++) step();
    #1;
    checks++;
    if (m_usr_vld !== 3'b001 || m_dsr_rdy !== 1'b0 || m_usr_dat !== 16'h00A0) begin
      errors++;
      $display("FAIL read_stall: usr_vld %b dsr_rdy %b usr_dat %h, required 001 0 00a0", m_usr_vld, m_dsr_rdy, m_usr_dat);
    end
    usr_rdy = '1;
    run(20, n);
    do_reset();
  endtask

  task automatic test_fifo_full();
    int n;
    dsw_rdy = 1'b0;
    push_cmd(0, 0, F_WR, 1'b1);
    push_cmd(0, 1, F_WR, 1'b1);
    push_cmd(0, 2, F_WR | F_EN, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wq[0].push_back(16'h00C0 + 16'(k));
      exp_w.push_back(16'h00C0 + 16'(k));
    end
    drive();
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (m_dsc_vld !== 1'b0 || m_lck !== 1'b1) begin
        errors++;
        $display("FAIL full_stall: dsc_vld %b lck %b, required 0 1", m_dsc_vld, m_lck);
      end
      step();
    end
    dsw_rdy = 1'b1;
    #1;
    checks++;
    if (m_dsc_vld !== 1'b0 || m_dsw_vld !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_same_cycle: dsc_vld %b dsw_vld %b, required 0 1", m_dsc_vld, m_dsw_vld);
    end
    step();
    #1;
    checks++;
    if (m_dsc_vld !== 1'b1) begin
      errors++;
      $display("FAIL full_release: dsc_vld %b, required 1", m_dsc_vld);
    end
    run(20, n);
    do_reset();
  endtask

  task automatic test_reset_midop();
    int n;
    push_cmd(0, 0, F_EN, 1'b1);
    drive();
    run(10, n);
    dsw_rdy = 1'b0;
    push_cmd(1, 0, F_WR, 1'b1);
    push_cmd(1, 1, F_WR, 1'b1);
    push_cmd(1, 2, F_WR | F_EN, 1'b0);
    for (int k = 0; k < 3; k++) wq[1].push_back(16'h00D0 + 16'(k));
    drive();
    step(); step(); step();
    #1;
    checks++;
    if (m_lck !== 1'b1 || m_own !== 2'd1 || m_dsw_vld !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: lck %b own %0d dsw_vld %b, required 1 1 1", m_lck, m_own, m_dsw_vld);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (m_lck !== 1'b0 || m_own !== '0 ||
        {m_dsc_vld, m_usc_rdy, m_dsw_vld, m_usw_rdy, m_usr_vld, m_dsr_rdy} !== '0) begin
      errors++;
      $display("FAIL midop_reset: lck %b own %0d dsc_vld %b usc_rdy %b dsw_vld %b usw_rdy %b, required all 0",
               m_lck, m_own, m_dsc_vld, m_usc_rdy, m_dsw_vld, m_usw_rdy);
    end
    cq[1].delete();
    wq[1].delete();
    dsw_rdy = 1'b1;
    push_cmd(0, 5, F_EN, 1'b1);
    push_cmd(2, 5, F_EN, 1'b1);
    drive();
    run(20, n);
    do_reset();
  endtask

  initial begin
    drive();
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_lock_enable();
    test_read_routing();
    test_fifo_full();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
